// File: rtl/xbar_assign_sequencer.sv
// Drives every N_VARS-bit assignment into the flow-based crossbar in ascending order,
// lets each one settle, samples f, and keeps the first satisfying assignment and the count.
//   state  | meaning
//   IDLE   | waiting for start, crossbar inputs parked at 0
//   SETTLE | current assignment applied, settle counter running
//   SAMPLE | one cycle, f is captured at the closing edge
//   DONE   | one-cycle completion pulse, results held
module xbar_assign_sequencer #(
  parameter int unsigned N_VARS      = 4,
  parameter int unsigned SETTLE      = 2,
  parameter bit          STOP_ON_SAT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_VARS-1:0] xbar_in,
  input  logic              xbar_f,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [N_VARS-1:0] sat_assign,
  output logic [N_VARS:0]   sat_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [7:0]        SETTLE_LD   = 8'(SETTLE);
  localparam logic [7:0]        CNT_ONE     = 8'd1;
  localparam logic [N_VARS-1:0] ASSIGN_LAST = '1;
  localparam logic [N_VARS-1:0] ASSIGN_ONE  = N_VARS'(1);
  localparam logic [N_VARS:0]   COUNT_ONE   = (N_VARS+1)'(1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_VARS-1:0]   assign_q, assign_d;
  logic [N_VARS-1:0]   xbar_in_q, xbar_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic [N_VARS-1:0]   sat_assign_q, sat_assign_d;
  logic [N_VARS:0]     sat_count_q, sat_count_d;
  logic                last_sample;

  // The run ends on the all-ones assignment, so assign never wraps.
  assign last_sample = (xbar_f && STOP_ON_SAT) || (assign_q == ASSIGN_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    assign_d     = assign_q;
    xbar_in_d    = xbar_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sat_d        = sat_q;
    sat_assign_d = sat_assign_q;
    sat_count_d  = sat_count_q;

    case (state_q)
      ST_IDLE: begin
        xbar_in_d = '0;
        busy_d    = 1'b0;
        if (start) begin
          sat_d        = 1'b0;
          sat_assign_d = '0;
          sat_count_d  = '0;
          assign_d     = '0;
          cnt_d        = SETTLE_LD;
          busy_d       = 1'b1;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          xbar_in_d = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_SAMPLE;
          end
        end
      end

      ST_SAMPLE: begin
        // An abort on the sample edge discards that sample entirely.
        if (abort) begin
          xbar_in_d = '0;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          if (xbar_f) begin
            sat_count_d = sat_count_q + COUNT_ONE;
            if (!sat_q) begin
              sat_d        = 1'b1;
              sat_assign_d = assign_q;
            end
          end
          if (last_sample) begin
            xbar_in_d = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            assign_d  = assign_q + ASSIGN_ONE;
            xbar_in_d = assign_q + ASSIGN_ONE;
            cnt_d     = SETTLE_LD;
            state_d   = ST_SETTLE;
          end
        end
      end

      ST_DONE: begin
        xbar_in_d = '0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        xbar_in_d = '0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      assign_q     <= '0;
      xbar_in_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
      sat_assign_q <= '0;
      sat_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      assign_q     <= assign_d;
      xbar_in_q    <= xbar_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
      sat_assign_q <= sat_assign_d;
      sat_count_q  <= sat_count_d;
    end
  end

  assign xbar_in    = xbar_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat        = sat_q;
  assign sat_assign = sat_assign_q;
  assign sat_count  = sat_count_q;

endmodule

// File: tb/tb_xbar_assign_sequencer.sv
// Bench for xbar_assign_sequencer: two instances (run-to-end and stop-on-sat) against
// a timeline model that derives the current assignment from cycles elapsed since start.
module tb_xbar_assign_sequencer;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int NA = 1 << N;
  localparam int P  = S + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic [N-1:0] xin  [2];
  logic         f    [2];
  logic         busy [2];
  logic         done [2];
  logic         sat  [2];
  logic [N-1:0] sa   [2];
  logic [N:0]   sc   [2];

  int           mode   = 0;
  logic [NA-1:0] tbl   = '0;
  logic         glitch [2] = '{1'b0, 1'b0};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic         m_act  [2] = '{1'b0, 1'b0};
  logic         m_done [2] = '{1'b0, 1'b0};
  logic         m_sat  [2] = '{1'b0, 1'b0};
  int           m_t    [2] = '{0, 0};
  logic [N-1:0] m_sa   [2] = '{'0, '0};
  logic [N:0]   m_sc   [2] = '{'0, '0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // mode: 0 = a&b, 1 = tied 0, 2 = tied 1, 3 = random truth table, 4 = high only while settling
  function automatic logic fn(input logic [N-1:0] a, input int md, input logic [NA-1:0] t,
                              input logic g);
    case (md)
      0:       return a[0] & a[1];
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return t[a];
      default: return g;
    endcase
  endfunction

  assign f[0] = fn(xin[0], mode, tbl, glitch[0]);
  assign f[1] = fn(xin[1], mode, tbl, glitch[1]);

  xbar_assign_sequencer #(.N_VARS(N), .SETTLE(S), .STOP_ON_SAT(1'b0)) u_full (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .xbar_in(xin[0]), .xbar_f(f[0]), .busy(busy[0]), .done(done[0]),
    .sat(sat[0]), .sat_assign(sa[0]), .sat_count(sc[0])
  );

  xbar_assign_sequencer #(.N_VARS(N), .SETTLE(S), .STOP_ON_SAT(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .xbar_in(xin[1]), .xbar_f(f[1]), .busy(busy[1]), .done(done[1]),
    .sat(sat[1]), .sat_assign(sa[1]), .sat_count(sc[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d at %0t", nm, i, act, want, $time);
    end
  endtask

  // Model: a run is a timeline of t edges after the accepting edge; every P-th edge is a sample.
  always @(posedge clk or negedge rst_n) begin : model
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_done[i] = 1'b0; m_t[i] = 0;
        m_sat[i] = 1'b0; m_sa[i] = '0; m_sc[i] = '0;
      end else if (m_done[i]) begin
        m_done[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1'b1; m_t[i] = 0;
          m_sat[i] = 1'b0; m_sa[i] = '0; m_sc[i] = '0;
        end
      end else begin
        m_t[i] = m_t[i] + 1;
        if (abort) begin
          m_act[i] = 1'b0;
        end else if (m_t[i] % P == 0) begin
          k = m_t[i] / P - 1;
          if (f[i]) begin
            m_sc[i] = m_sc[i] + 1'b1;
            if (!m_sat[i]) begin
              m_sat[i] = 1'b1;
              m_sa[i]  = N'(k);
            end
          end
          if ((f[i] && i == 1) || k == NA - 1) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
      chk("done", i, 32'(done[i]), 32'(m_done[i]));
      chk("xbar_in", i, 32'(xin[i]), m_act[i] ? 32'(m_t[i] / P) : 32'd0);
      chk("sat", i, 32'(sat[i]), 32'(m_sat[i]));
      chk("sat_assign", i, 32'(sa[i]), 32'(m_sa[i]));
      chk("sat_count", i, 32'(sc[i]), 32'(m_sc[i]));
      glitch[i] = m_act[i] && ((m_t[i] + 1) % P != 0);
    end
  end

  task automatic run(input int md, input int extra_at, input int abort_at,
                     output int b0, output int d0, output int d1, output int mx);
    int  e0;
    bit  fin;
    mode = md;
    tbl  = NA'($urandom);
    b0 = 0; d0 = -1; d1 = -1; mx = 0; fin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e0 = cyc;
    for (int c = 0; c < 300 && !fin; c++) begin
      if (busy[0]) b0++;
      if (int'(xin[1]) > mx) mx = int'(xin[1]);
      if (done[0]) d0 = cyc - e0;
      if (done[1]) d1 = cyc - e0;
      start = (c == extra_at);
      abort = (c == abort_at);
      if (c > 0 && !busy[0] && !busy[1] && !done[0] && !done[1]) fin = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    chk("run_finished", 0, 32'(fin), 32'd1);
  endtask

  task automatic chk_all_zero(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_busy"}, i, 32'(busy[i]), 32'd0);
      chk({nm, "_done"}, i, 32'(done[i]), 32'd0);
      chk({nm, "_xbar_in"}, i, 32'(xin[i]), 32'd0);
      chk({nm, "_sat"}, i, 32'(sat[i]), 32'd0);
      chk({nm, "_sat_assign"}, i, 32'(sa[i]), 32'd0);
      chk({nm, "_sat_count"}, i, 32'(sc[i]), 32'd0);
    end
  endtask

  initial begin : stim
    int b0, d0, d1, mx;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // f = a&b, stray start at E0+5 must be ignored
    run(0, 4, -1, b0, d0, d1, mx);
    chk("and_done_at", 0, 32'(d0), 32'd48);
    chk("and_busy_cycles", 0, 32'(b0), 32'd48);
    chk("and_sat", 0, 32'(sat[0]), 32'd1);
    chk("and_sat_assign", 0, 32'(sa[0]), 32'd3);
    chk("and_sat_count", 0, 32'(sc[0]), 32'd4);
    chk("and_stop_done_at", 1, 32'(d1), 32'd12);
    chk("and_stop_sat_assign", 1, 32'(sa[1]), 32'd3);
    chk("and_stop_sat_count", 1, 32'(sc[1]), 32'd1);
    chk("and_stop_xbar_in_le3", 1, 32'(mx <= 3), 32'd1);

    run(1, -1, -1, b0, d0, d1, mx);
    chk("zero_done_at", 0, 32'(d0), 32'd48);
    chk("zero_sat", 0, 32'(sat[0]), 32'd0);
    chk("zero_sat_count", 0, 32'(sc[0]), 32'd0);
    chk("zero_stop_done_at", 1, 32'(d1), 32'd48);

    run(2, -1, -1, b0, d0, d1, mx);
    chk("one_sat_count", 0, 32'(sc[0]), 32'd16);
    chk("one_sat_assign", 0, 32'(sa[0]), 32'd0);
    chk("one_stop_done_at", 1, 32'(d1), 32'd3);
    chk("one_stop_sat_count", 1, 32'(sc[1]), 32'd1);

    run(4, -1, -1, b0, d0, d1, mx);
    chk("glitch_sat_count", 0, 32'(sc[0]), 32'd0);
    chk("glitch_stop_sat_count", 1, 32'(sc[1]), 32'd0);
    chk("glitch_done_at", 0, 32'(d0), 32'd48);

    // abort sampled at E0+20, then a clean rerun
    run(0, -1, 19, b0, d0, d1, mx);
    chk("abort_no_done", 0, 32'(d0), 32'hFFFF_FFFF);
    chk("abort_busy_cycles", 0, 32'(b0), 32'd20);
    chk("abort_kept_count", 0, 32'(sc[0]), 32'd1);
    chk("abort_kept_assign", 0, 32'(sa[0]), 32'd3);
    run(0, -1, -1, b0, d0, d1, mx);
    chk("rerun_done_at", 0, 32'(d0), 32'd48);
    chk("rerun_sat_count", 0, 32'(sc[0]), 32'd4);

    // abort on the final sample edge beats the sample
    run(2, -1, 47, b0, d0, d1, mx);
    chk("abort_final_no_done", 0, 32'(d0), 32'hFFFF_FFFF);
    chk("abort_final_count", 0, 32'(sc[0]), 32'd15);

    // asynchronous reset mid-run
    mode  = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(0, -1, -1, b0, d0, d1, mx);
    chk("post_reset_done_at", 0, 32'(d0), 32'd48);
    chk("post_reset_sat_count", 0, 32'(sc[0]), 32'd4);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 29) == 0);
      abort = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 199) == 0) begin
        mode = int'($urandom_range(0, 4));
        tbl  = NA'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (60) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
